// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver states, parity modes, oversampling ratio
// and the channel-index width helper.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP,
    BRK
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  localparam int OSR = 16;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_os_tick.sv
// Free-running oversample tick: one-clock pulse every CLK_DIV clocks.
module uart_os_tick #(
  parameter int CLK_DIV = 27
) (
  input  logic clock,
  input  logic rst,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clock) begin
    if (rst)       cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_router.sv
// 16x oversampled UART receiver whose first character after an idle gap
// selects the output channel for the following payload characters.
module uart_rx_router import uart_pkg::*; #(
  parameter int          CLK_DIV   = 27,
  parameter int          DATA_BITS = 8,
  parameter int          PARITY    = 0,
  parameter int          NUM_CH    = 2,
  parameter int unsigned HDR_BASE  = 'hA0,
  parameter int          IDLE_BITS = 10,
  localparam int         CH_W      = ch_w(NUM_CH)
) (
  input  logic                          clock,
  input  logic                          rst,
  input  logic                          rx,
  output logic [NUM_CH*DATA_BITS-1:0]   ch_data,
  output logic [NUM_CH-1:0]             ch_valid,
  output logic                          ch_active,
  output logic [CH_W-1:0]               active_ch,
  output logic                          parity_err,
  output logic                          frame_err,
  output logic                          hdr_err
);

  localparam int PH_W = $clog2(OSR);
  localparam int BC_W = $clog2(DATA_BITS);
  localparam int IC_W = $clog2(IDLE_BITS + 1);
  localparam logic [PH_W-1:0]      MID = PH_W'(OSR / 2 - 1);
  localparam logic [DATA_BITS-1:0] HB  = DATA_BITS'(HDR_BASE);

  logic rx_meta, rxs, rxs_d;
  logic tick, samp, fall;
  rx_state_e state, state_nx;
  logic [PH_W-1:0] phase, idle_ph;
  logic [BC_W-1:0] bit_cnt;
  logic [DATA_BITS-1:0] shreg, hdr_off;
  logic [IC_W-1:0] idle_cnt;
  logic par_bad, hdr_cand, hdr_ok;
  logic start_det, accept, perr, ferr, bit_done, idle_sat, wr_pay;
  logic [NUM_CH-1:0][DATA_BITS-1:0] ch_q;

  uart_os_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock (clock),
    .rst   (rst),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (rst) {rx_meta, rxs, rxs_d} <= 3'b111;
    else     {rx_meta, rxs, rxs_d} <= {rx, rx_meta, rxs};
  end

  assign fall = rxs_d & ~rxs;
  assign samp = tick && (phase == MID);

  always_ff @(posedge clock) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (fall) state_nx = START;
      START: if (samp) state_nx = rxs ? IDLE : DATA;
      DATA:  if (samp && bit_cnt == BC_W'(DATA_BITS - 1))
               state_nx = (PARITY != PAR_NONE) ? PAR : STOP;
      PAR:   if (samp) state_nx = STOP;
      STOP:  if (samp) state_nx = rxs ? IDLE : BRK;
      BRK:   if (rxs)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    start_det = (state == IDLE) && fall;
    accept    = (state == STOP) && samp && rxs && !par_bad;
    perr      = (state == STOP) && samp && rxs && par_bad;
    ferr      = (state == STOP) && samp && !rxs;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      phase   <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bad <= 1'b0;
    end else begin
      if (start_det) phase <= '0;
      else if (tick) phase <= phase + 1'b1;
      if (start_det) begin
        bit_cnt <= '0;
        par_bad <= 1'b0;
      end else if (state == DATA && samp) begin
        shreg   <= {rxs, shreg[DATA_BITS-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end else if (state == PAR && samp) begin
        par_bad <= (^{shreg, rxs}) != (PARITY == PAR_ODD);
      end
    end
  end

  // Idle bit-times use the previous line sample so a bit that completes on
  // the start-edge clock still saturates the counter (header candidate).
  assign bit_done = (state == IDLE) && rxs_d && tick && (idle_ph == PH_W'(OSR - 1));
  assign idle_sat = (idle_cnt == IC_W'(IDLE_BITS)) ||
                    (bit_done && idle_cnt == IC_W'(IDLE_BITS - 1));

  always_ff @(posedge clock) begin
    if (rst) begin
      idle_ph  <= '0;
      idle_cnt <= '0;
      hdr_cand <= 1'b0;
    end else begin
      if (state != IDLE || !rxs_d) idle_ph <= '0;
      else if (tick)               idle_ph <= idle_ph + 1'b1;
      if (start_det)
        idle_cnt <= '0;
      else if (bit_done && idle_cnt != IC_W'(IDLE_BITS))
        idle_cnt <= idle_cnt + 1'b1;
      if (start_det) hdr_cand <= idle_sat;
    end
  end

  assign hdr_off = shreg - HB;
  assign hdr_ok  = 32'(hdr_off) < 32'(NUM_CH);
  assign wr_pay  = accept && ch_active;

  always_ff @(posedge clock) begin
    if (rst) begin
      ch_active  <= 1'b0;
      active_ch  <= '0;
      hdr_err    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= perr;
      frame_err  <= ferr;
      hdr_err    <= accept && !ch_active && hdr_cand && !hdr_ok;
      if (idle_sat)
        ch_active <= 1'b0;
      else if (accept && !ch_active && hdr_cand && hdr_ok) begin
        ch_active <= 1'b1;
        active_ch <= CH_W'(hdr_off);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      ch_q     <= '0;
      ch_valid <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        ch_valid[k] <= wr_pay && (active_ch == CH_W'(k));
        if (wr_pay && active_ch == CH_W'(k)) ch_q[k] <= shreg;
      end
    end
  end

  assign ch_data = ch_q;

endmodule
